// File: rtl/pong_engine.sv
// ---------------------------------------------------------------------------
// pong_engine
//   Frame-rate game-state engine for Pong. Owns both paddles, the ball
//   (position and velocity), wall/paddle collisions, scoring and the
//   serve -> play -> point -> game-over flow. All state advances only on a
//   clk edge where frame_tick is high; outputs hold between ticks.
//
//   Optional build macro: PONG_ANGLE_EN
//     When defined, the part of the paddle that a ball hits picks the
//     ball's vertical direction (top third up, bottom third down, middle
//     third unchanged). When undefined, paddle hits never change vy.
//
//   Ports
//     clk                  : system/pixel clock
//     rst                  : synchronous reset, active-high
//     frame_tick           : one-cycle pulse per frame, advances the game
//     p1_up/p1_dn/p1_srv   : player 1 controls (level, active-high)
//     p2_up/p2_dn/p2_srv   : player 2 controls (level, active-high)
//     p1_y, p2_y           : paddle top y
//     ball_x, ball_y       : ball top-left
//     p1_score, p2_score   : scores
//     state                : 0=SERVE 1=PLAY 2=POINT 3=OVER
//     game_over            : high while in OVER
//
//   Handshake: none. frame_tick is a strobe; inputs are sampled on the
//   edge where frame_tick=1 and the result is visible one clk later.
// ---------------------------------------------------------------------------
module pong_engine #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 50,
    parameter int BALL_SZ      = 10,
    parameter int P1_X         = 40,
    parameter int P2_X         = 600,
    parameter int PADDLE_SPD   = 4,
    parameter int BALL_SPD     = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int POINT_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_dn,
    input  logic               p1_srv,
    input  logic               p2_up,
    input  logic               p2_dn,
    input  logic               p2_srv,
    output logic [9:0]         p1_y,
    output logic [9:0]         p2_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [1:0]         state,
    output logic               game_over
);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int HOLD_W = $clog2(POINT_FRAMES + 1);

    localparam logic [9:0] C_PAD_Y0   = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] C_BALL_X0  = 10'((SCREEN_W - BALL_SZ) / 2);
    localparam logic [9:0] C_BALL_Y0  = 10'((SCREEN_H - BALL_SZ) / 2);
    localparam logic [9:0] C_PAD_MAX  = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0] C_BY_MAX   = 10'(SCREEN_H - BALL_SZ);
    localparam logic [9:0] C_P1_STOP  = 10'(P1_X + PADDLE_W);
    localparam logic [9:0] C_P2_STOP  = 10'(P2_X - BALL_SZ);

    // Signed 11-bit working constants: positions plus velocity can go
    // slightly negative or past the screen edge without wrapping.
    localparam logic signed [10:0] S_ZERO     = 11'sd0;
    localparam logic signed [10:0] S_PAD_MAX  = 11'(SCREEN_H - PADDLE_H);
    localparam logic signed [10:0] S_BX_MAX   = 11'(SCREEN_W - BALL_SZ);
    localparam logic signed [10:0] S_BY_MAX   = 11'(SCREEN_H - BALL_SZ);
    localparam logic signed [10:0] S_PAD_SPD  = 11'(PADDLE_SPD);
    localparam logic signed [10:0] S_BALL_SPD = 11'(BALL_SPD);
    localparam logic signed [10:0] S_BALL_SZ  = 11'(BALL_SZ);
    localparam logic signed [10:0] S_PAD_H    = 11'(PADDLE_H);
    localparam logic signed [10:0] S_P1_X     = 11'(P1_X);
    localparam logic signed [10:0] S_P1_RIGHT = 11'(P1_X + PADDLE_W);
    localparam logic signed [10:0] S_P2_X     = 11'(P2_X);
    localparam logic signed [10:0] S_P2_RIGHT = 11'(P2_X + PADDLE_W);

    localparam logic [SCORE_W-1:0] C_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]  C_HOLD = HOLD_W'(POINT_FRAMES - 1);

    // Registered game state
    state_t              r_state;
    logic                r_game_over;
    logic                r_server_p2;   // 0: P1 serves, 1: P2 serves
    logic                r_vx_neg;      // ball moving left
    logic                r_vy_neg;      // ball moving up
    logic [9:0]          r_p1_y;
    logic [9:0]          r_p2_y;
    logic [9:0]          r_ball_x;
    logic [9:0]          r_ball_y;
    logic [SCORE_W-1:0]  r_p1_score;
    logic [SCORE_W-1:0]  r_p2_score;
    logic [HOLD_W-1:0]   r_hold;

    // Move a paddle by one step and clamp it to the playfield.
    function automatic logic [9:0] f_paddle_next(input logic [9:0] cur,
                                                 input logic       up,
                                                 input logic       dn);
        logic signed [10:0] v;
        v = $signed({1'b0, cur});
        if (up && !dn) begin
            v = v - S_PAD_SPD;
        end else if (dn && !up) begin
            v = v + S_PAD_SPD;
        end
        if (v < S_ZERO) begin
            return 10'd0;
        end else if (v > S_PAD_MAX) begin
            return C_PAD_MAX;
        end
        return v[9:0];
    endfunction

    logic [9:0]          w_p1_next;
    logic [9:0]          w_p2_next;
    logic signed [10:0]  w_p1_top;
    logic signed [10:0]  w_p2_top;
    logic signed [10:0]  w_vx;
    logic signed [10:0]  w_vy;
    logic signed [10:0]  w_nx;
    logic signed [10:0]  w_ny;
    logic                w_score_p2;
    logic                w_score_p1;
    logic                w_p1_hit;
    logic                w_p2_hit;
    logic                w_srv_ok;
    logic [SCORE_W-1:0]  w_p1_inc;
    logic [SCORE_W-1:0]  w_p2_inc;
    logic                w_win;
    logic [9:0]          w_hit_bx;
    logic                w_hit_vx_neg;
    logic                w_pad_vy_neg;
    logic [9:0]          w_new_by;
    logic                w_new_vy_neg;

    assign w_p1_next = f_paddle_next(r_p1_y, p1_up, p1_dn);
    assign w_p2_next = f_paddle_next(r_p2_y, p2_up, p2_dn);

    assign w_p1_top = $signed({1'b0, r_p1_y});
    assign w_p2_top = $signed({1'b0, r_p2_y});
    assign w_vx     = r_vx_neg ? -S_BALL_SPD : S_BALL_SPD;
    assign w_vy     = r_vy_neg ? -S_BALL_SPD : S_BALL_SPD;
    assign w_nx     = $signed({1'b0, r_ball_x}) + w_vx;
    assign w_ny     = $signed({1'b0, r_ball_y}) + w_vy;

    // Scoring takes priority over any collision.
    assign w_score_p2 = (w_nx <= S_ZERO);
    assign w_score_p1 = !w_score_p2 && (w_nx >= S_BX_MAX);

    // Paddle collisions use the paddle position from before this frame's move.
    assign w_p1_hit = r_vx_neg && (w_nx <= S_P1_RIGHT) && (w_nx + S_BALL_SZ > S_P1_X)
                   && (w_ny + S_BALL_SZ > w_p1_top) && (w_ny < w_p1_top + S_PAD_H);
    assign w_p2_hit = !r_vx_neg && (w_nx + S_BALL_SZ >= S_P2_X) && (w_nx < S_P2_RIGHT)
                   && (w_ny + S_BALL_SZ > w_p2_top) && (w_ny < w_p2_top + S_PAD_H);

    assign w_srv_ok = r_server_p2 ? p2_srv : p1_srv;
    assign w_p1_inc = r_p1_score + SCORE_W'(1);
    assign w_p2_inc = r_p2_score + SCORE_W'(1);
    assign w_win    = w_score_p1 ? (w_p1_inc == C_WIN) : (w_p2_inc == C_WIN);

    always_comb begin
        w_hit_bx     = w_nx[9:0];
        w_hit_vx_neg = r_vx_neg;
        if (w_p1_hit) begin
            w_hit_bx     = C_P1_STOP;
            w_hit_vx_neg = 1'b0;
        end else if (w_p2_hit) begin
            w_hit_bx     = C_P2_STOP;
            w_hit_vx_neg = 1'b1;
        end
    end

`ifdef PONG_ANGLE_EN
    localparam logic signed [10:0] S_BALL_HALF = 11'(BALL_SZ / 2);
    localparam logic signed [12:0] S_THIRD_1   = 13'(PADDLE_H);
    localparam logic signed [12:0] S_THIRD_2   = 13'(2 * PADDLE_H);

    logic signed [10:0] w_pad_top;
    logic signed [10:0] w_rel;
    logic signed [12:0] w_rel3;

    // Ball centre relative to the struck paddle's top, scaled by 3 so the
    // thirds compare against PADDLE_H and 2*PADDLE_H without division.
    assign w_pad_top = w_p1_hit ? w_p1_top : w_p2_top;
    assign w_rel     = w_ny + S_BALL_HALF - w_pad_top;
    assign w_rel3    = $signed({{2{w_rel[10]}}, w_rel}) * 13'sd3;

    always_comb begin
        w_pad_vy_neg = r_vy_neg;
        if (w_p1_hit || w_p2_hit) begin
            if (w_rel3 < S_THIRD_1) begin
                w_pad_vy_neg = 1'b1;
            end else if (w_rel3 >= S_THIRD_2) begin
                w_pad_vy_neg = 1'b0;
            end
        end
    end
`else
    assign w_pad_vy_neg = r_vy_neg;
`endif

    // Walls apply after any paddle deflection.
    always_comb begin
        w_new_by     = w_ny[9:0];
        w_new_vy_neg = w_pad_vy_neg;
        if (w_ny <= S_ZERO) begin
            w_new_by     = 10'd0;
            w_new_vy_neg = 1'b0;
        end else if (w_ny >= S_BY_MAX) begin
            w_new_by     = C_BY_MAX;
            w_new_vy_neg = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SERVE;
            r_game_over <= 1'b0;
            r_server_p2 <= 1'b0;
            r_vx_neg    <= 1'b0;
            r_vy_neg    <= 1'b0;
            r_p1_y      <= C_PAD_Y0;
            r_p2_y      <= C_PAD_Y0;
            r_ball_x    <= C_BALL_X0;
            r_ball_y    <= C_BALL_Y0;
            r_p1_score  <= '0;
            r_p2_score  <= '0;
            r_hold      <= '0;
        end else if (frame_tick) begin
            if (r_state != ST_OVER) begin
                r_p1_y <= w_p1_next;
                r_p2_y <= w_p2_next;
            end
            case (r_state)
                ST_SERVE: begin
                    if (w_srv_ok) begin
                        r_vx_neg <= r_server_p2;   // launch away from the server
                        r_vy_neg <= 1'b0;
                        r_state  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_score_p1 || w_score_p2) begin
                        r_ball_x    <= C_BALL_X0;
                        r_ball_y    <= C_BALL_Y0;
                        r_server_p2 <= w_score_p1;  // loser serves next
                        if (w_score_p1) begin
                            r_p1_score <= w_p1_inc;
                        end else begin
                            r_p2_score <= w_p2_inc;
                        end
                        if (w_win) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state <= ST_POINT;
                            r_hold  <= C_HOLD;
                        end
                    end else begin
                        r_ball_x <= w_hit_bx;
                        r_ball_y <= w_new_by;
                        r_vx_neg <= w_hit_vx_neg;
                        r_vy_neg <= w_new_vy_neg;
                    end
                end
                ST_POINT: begin
                    if (r_hold == '0) begin
                        r_state <= ST_SERVE;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                ST_OVER: begin
                    if (p1_srv || p2_srv) begin
                        r_p1_score  <= '0;
                        r_p2_score  <= '0;
                        r_server_p2 <= 1'b0;
                        r_ball_x    <= C_BALL_X0;
                        r_ball_y    <= C_BALL_Y0;
                        r_state     <= ST_SERVE;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= ST_SERVE;
            endcase
        end
    end

    assign p1_y      = r_p1_y;
    assign p2_y      = r_p2_y;
    assign ball_x    = r_ball_x;
    assign ball_y    = r_ball_y;
    assign p1_score  = r_p1_score;
    assign p2_score  = r_p2_score;
    assign state     = r_state;
    assign game_over = r_game_over;

endmodule

// File: doc/pong_engine.md
Name: pong_engine

Overview:
- Frame-rate game-state engine for the Pong top level.
- Owns both paddle positions, ball position and velocity, wall and paddle collisions, scoring, and the serve/point/game-over flow.
- Advances exactly one step per frame_tick pulse, generated by the VGA timing block at the start of vertical blanking.
- Outputs are sprite top-left coordinates that feed the sprite instances directly.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- PADDLE_W, 10, paddle width
- PADDLE_H, 50, paddle height
- BALL_SZ, 10, ball width and height
- P1_X, 40, fixed x of the P1 paddle
- P2_X, 600, fixed x of the P2 paddle
- PADDLE_SPD, 4, paddle pixels per frame
- BALL_SPD, 2, ball pixels per frame on each axis
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, score that ends the game
- POINT_FRAMES, 60, frames the engine holds after a point

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse, one per frame
- p1_up, p1_dn, p1_srv  in  1 each  P1 controls, level, active-high
- p2_up, p2_dn, p2_srv  in  1 each  P2 controls, level, active-high
- p1_y, p2_y  out  10  paddle top y
- ball_x, ball_y  out  10  ball top-left
- p1_score, p2_score  out  SCORE_W  scores
- state  out  2  0=SERVE, 1=PLAY, 2=POINT, 3=OVER
- game_over  out  1  high while in OVER

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - p1_y = p2_y = (SCREEN_H-PADDLE_H)/2
  - ball = ((SCREEN_W-BALL_SZ)/2, (SCREEN_H-BALL_SZ)/2)
  - scores = 0, state = SERVE, server = P1, velocity = (+BALL_SPD, +BALL_SPD)
  - hold counter = 0
- Update timing:
  - All state changes occur only on a clk edge where frame_tick=1.
  - Outputs hold between ticks.
  - Latency is one clk from the sampled tick.
  - Reset has priority over frame_tick.
- Paddles (SERVE, PLAY, POINT):
  - up subtracts PADDLE_SPD; dn adds PADDLE_SPD.
  - up and dn both high: no move.
  - Result clamps to [0, SCREEN_H-PADDLE_H].
  - Arithmetic is done in 11-bit signed, so there is no wrap.
  - Paddles are frozen in OVER.
- SERVE:
  - Ball is parked at center.
  - On the server's srv input only: velocity x points away from the server, y = +BALL_SPD, go to PLAY.
  - The other player's srv is ignored.
- PLAY, next position n = pos + vel (signed, 11-bit), evaluated in this priority:
  1. Score: nx <= 0 gives a P2 point; nx >= SCREEN_W-BALL_SZ gives a P1 point. The scorer's counter increments, the loser becomes server, the ball parks at center. Go to POINT with hold = POINT_FRAMES-1, or to OVER if the new score == WIN_SCORE.
  2. Paddle hit, when vx<0 and nx <= P1_X+PADDLE_W and nx+BALL_SZ > P1_X and vertical overlap (ny+BALL_SZ > p1_y and ny < p1_y+PADDLE_H): vx := +BALL_SPD, ball_x := P1_X+PADDLE_W. P2 is mirrored (vx>0, ball_x := P2_X-BALL_SZ). Paddle y used is the pre-update value.
  3. Walls: ny <= 0 sets ny := 0 and vy := +BALL_SPD; ny >= SCREEN_H-BALL_SZ clamps ny and sets vy := -BALL_SPD. A wall hit may coincide with a paddle hit; both apply.
- POINT:
  - Hold decrements per tick.
  - At 0, go to SERVE.
  - srv inputs are ignored.
- OVER:
  - game_over=1.
  - Either srv input: scores := 0, server := P1, ball centered, go to SERVE.
- Scores never exceed WIN_SCORE, so there is no counter wrap.

Optional Feature:
- Macro PONG_ANGLE_EN.
- When defined, paddle hit position sets the ball's vertical direction:
  - ball centre in the top third of the paddle: vy := -BALL_SPD
  - bottom third: vy := +BALL_SPD
  - middle third: vy unchanged
- Wall handling still applies after this.
- When undefined, paddle hits never alter vy.

Test Plan:
- Reset, then 3 ticks with no inputs → p1_y=p2_y=215, ball=(315,235), state=0, scores 0.
- p1_up held for 60 ticks → p1_y decreases by 4 per tick to 0, then holds at 0. p1_up+p1_dn together → p1_y unchanged.
- p2_srv in SERVE → ignored. p1_srv → state=1, ball moves (+2,+2) per tick. Bottom wall reached → ball_y=470, vy negative next tick.
- P2 paddle aligned with the ball path → ball_x snaps to 590, vx=-2, and no score increments.
- P2 paddle parked at y=0 with the ball low → ball reaches 630, p1_score=1, state=2 for 60 ticks, then state=0 with server=P2 (only p2_srv launches, toward P1).
- Drive P1 to 9 points → state=3, game_over=1, paddles frozen. Any srv → scores 0, state=0. With PONG_ANGLE_EN, a top-third hit yields vy=-2.
